// File: rtl/sysid_arbiter.sv
// Boot-time ID/timestamp checker plus two-master read arbiter in front of the sysid slave.
// Optional macro SYSID_ARB_CACHE_EN: serve reads from the captured boot words instead of the slave.
module sysid_arbiter #(
  parameter logic [31:0] EXPECTED_ID   = 32'd0,
  parameter logic [31:0] EXPECTED_TS   = 32'd1390855222,
  parameter int          CHECK_RETRIES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_address,
  input  logic        m0_read,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_address,
  input  logic        m1_read,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        boot_done,
  output logic        id_ok,
  output logic        id_fail
);

  typedef enum logic [1:0] {BOOT_ID, BOOT_TS, CHECK, SERVE} state_t;

  localparam logic [3:0] LAST_ATTEMPT = 4'(CHECK_RETRIES - 1);

  state_t      state_reg, state_next;
  logic [31:0] id_q, ts_q;
  logic [3:0]  attempt_reg;
  logic        boot_done_reg, id_ok_reg, id_fail_reg;
  logic        capture_id, capture_ts, retry, pass, fail;
  logic        serve;
  logic [1:0]  req, addr, grant;

  assign req   = {m1_read, m0_read};
  assign addr  = {m1_address, m0_address};
  assign serve = (state_reg == SERVE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= BOOT_ID;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    capture_id = 1'b0;
    capture_ts = 1'b0;
    retry      = 1'b0;
    pass       = 1'b0;
    fail       = 1'b0;
    case (state_reg)
      BOOT_ID: begin
        capture_id = 1'b1;
        state_next = BOOT_TS;
      end
      BOOT_TS: begin
        capture_ts = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        if (id_q == EXPECTED_ID && ts_q == EXPECTED_TS) begin
          pass       = 1'b1;
          state_next = SERVE;
        end else if (attempt_reg == LAST_ATTEMPT) begin
          fail       = 1'b1;
          state_next = SERVE;
        end else begin
          retry      = 1'b1;
          state_next = BOOT_ID;
        end
      end
      SERVE:   state_next = SERVE;
      default: state_next = BOOT_ID;
    endcase
  end

  // Captured words and result flags; the flags are sticky until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q          <= '0;
      ts_q          <= '0;
      attempt_reg   <= '0;
      boot_done_reg <= 1'b0;
      id_ok_reg     <= 1'b0;
      id_fail_reg   <= 1'b0;
    end else begin
      if (capture_id)  id_q <= sid_readdata;
      if (capture_ts)  ts_q <= sid_readdata;
      if (retry)       attempt_reg <= attempt_reg + 4'd1;
      if (pass)        id_ok_reg <= 1'b1;
      if (fail)        id_fail_reg <= 1'b1;
      if (pass | fail) boot_done_reg <= 1'b1;
    end
  end

  assign boot_done = boot_done_reg;
  assign id_ok     = id_ok_reg;
  assign id_fail   = id_fail_reg;

`ifdef SYSID_ARB_CACHE_EN
  // Answers come from local copies, so both masters can be accepted together.
  assign grant = serve ? req : 2'b00;
`else
  logic last_reg;

  // On a tie the master that was not granted most recently wins.
  always_comb begin
    grant = 2'b00;
    if (serve) begin
      if (req[0] && (!req[1] || last_reg)) grant[0] = 1'b1;
      else if (req[1])                     grant[1] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         last_reg <= 1'b1;
    else if (grant[0]) last_reg <= 1'b0;
    else if (grant[1]) last_reg <= 1'b1;
  end
`endif

  always_comb begin
    sid_address = 1'b0;
    if (state_reg == BOOT_TS) sid_address = 1'b1;
`ifndef SYSID_ARB_CACHE_EN
    else if (serve) sid_address = |(grant & addr);
`endif
  end

  assign m0_waitrequest = ~grant[0];
  assign m1_waitrequest = ~grant[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [31:0] src;
      logic        pend_valid;
      logic [31:0] pend_data;
      logic        rdv;
      logic [31:0] rdata;

`ifdef SYSID_ARB_CACHE_EN
      assign src = addr[gi] ? ts_q : id_q;
`else
      assign src = sid_readdata;
`endif

      // Data sampled at the accept edge is presented one edge later.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pend_valid <= 1'b0;
          pend_data  <= '0;
          rdv        <= 1'b0;
          rdata      <= '0;
        end else begin
          pend_valid <= grant[gi];
          if (grant[gi]) pend_data <= src;
          rdv <= pend_valid;
          if (pend_valid) rdata <= pend_data;
        end
      end
    end
  endgenerate

  assign m0_readdata      = g_port[0].rdata;
  assign m0_readdatavalid = g_port[0].rdv;
  assign m1_readdata      = g_port[1].rdata;
  assign m1_readdatavalid = g_port[1].rdv;

endmodule

// File: tb/tb_sysid_arbiter.sv
// Directed bench for sysid_arbiter: boot pass/fail, pass-through reads, round-robin, reset abort.
// Also exercises the SYSID_ARB_CACHE_EN build when that macro is defined.
module tb_sysid_arbiter;

  localparam logic [31:0] TS = 32'd1390855222;

  logic        clock;
  logic        reset;
  logic        m0_address, m0_read, m0_waitrequest, m0_readdatavalid;
  logic [31:0] m0_readdata;
  logic        m1_address, m1_read, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m1_readdata;
  logic        sid_address;
  logic [31:0] sid_readdata;
  logic        boot_done, id_ok, id_fail;
  logic [31:0] id_val;

  int n_checks = 0;
  int n_fail   = 0;

  sysid_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sid_address(sid_address), .sid_readdata(sid_readdata),
    .boot_done(boot_done), .id_ok(id_ok), .id_fail(id_fail)
  );

  // Zero-latency sysid slave model.
  assign sid_readdata = sid_address ? TS : id_val;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_read = 1'b0; m1_read = 1'b0;
    m0_address = 1'b0; m1_address = 1'b0;
    @(posedge clock);
    #1;
    check("rst_wr0", m0_waitrequest, 1);
    check("rst_wr1", m1_waitrequest, 1);
    check("rst_rdv0", m0_readdatavalid, 0);
    check("rst_rdv1", m1_readdatavalid, 0);
    check("rst_rdata0", m0_readdata, 0);
    check("rst_rdata1", m1_readdata, 0);
    check("rst_sid_addr", sid_address, 0);
    check("rst_boot_done", boot_done, 0);
    check("rst_id_ok", id_ok, 0);
    check("rst_id_fail", id_fail, 0);
    reset = 1'b0;
  endtask

  logic [5:0] exp_wr0, exp_wr1, exp_rdv0, exp_rdv1;
  int ts_cycles;

  initial begin
    reset = 1'b1;
    id_val = 32'd0;
    m0_read = 1'b0; m1_read = 1'b0;
    m0_address = 1'b0; m1_address = 1'b0;

    // Passing boot: flags after edge 3.
    do_reset();
    check("boot_id_addr", sid_address, 0);
    tick();
    check("boot_ts_addr", sid_address, 1);
    tick();
    check("check_not_done", boot_done, 0);
    tick();
    check("pass_boot_done", boot_done, 1);
    check("pass_id_ok", id_ok, 1);
    check("pass_id_fail", id_fail, 0);

`ifdef SYSID_ARB_CACHE_EN
    // Both masters accepted together from the cached words.
    m0_read = 1'b1; m0_address = 1'b0;
    m1_read = 1'b1; m1_address = 1'b1;
    #1;
    check("cache_wr0", m0_waitrequest, 0);
    check("cache_wr1", m1_waitrequest, 0);
    check("cache_sid_addr", sid_address, 0);
    tick();
    m0_read = 1'b0; m1_read = 1'b0;
    check("cache_rdv0_early", m0_readdatavalid, 0);
    tick();
    check("cache_rdv0", m0_readdatavalid, 1);
    check("cache_rdv1", m1_readdatavalid, 1);
    check("cache_data0", m0_readdata, 0);
    check("cache_data1", m1_readdata, TS);
    check("cache_sid_addr2", sid_address, 0);
    tick();
`endif

    // m1 alone, back-to-back reads of 0, 1, 0.
    m1_read = 1'b1; m1_address = 1'b0;
    #1;
    check("b2b_wr1_a", m1_waitrequest, 0);
    tick();
    check("b2b_rdv1_early", m1_readdatavalid, 0);
    m1_address = 1'b1;
    #1;
    check("b2b_wr1_b", m1_waitrequest, 0);
    tick();
    check("b2b_rdv1_a", m1_readdatavalid, 1);
    check("b2b_data_a", m1_readdata, 0);
    m1_address = 1'b0;
    #1;
    check("b2b_wr1_c", m1_waitrequest, 0);
    tick();
    m1_read = 1'b0;
    check("b2b_rdv1_b", m1_readdatavalid, 1);
    check("b2b_data_b", m1_readdata, TS);
    tick();
    check("b2b_rdv1_c", m1_readdatavalid, 1);
    check("b2b_data_c", m1_readdata, 0);
    check("b2b_rdv0", m0_readdatavalid, 0);
    tick();
    check("b2b_rdv1_end", m1_readdatavalid, 0);
    check("b2b_hold", m1_readdata, 0);

`ifndef SYSID_ARB_CACHE_EN
    // Both masters hold reads on address 1: grants m0, m1, m0, m1.
    exp_wr0  = 6'b111010;
    exp_wr1  = 6'b110101;
    exp_rdv0 = 6'b001010;
    exp_rdv1 = 6'b010100;
    for (int i = 0; i < 6; i++) begin
      m0_read = (i < 4); m1_read = (i < 4);
      m0_address = 1'b1; m1_address = 1'b1;
      #1;
      check($sformatf("rr_wr0_%0d", i), m0_waitrequest, exp_wr0[i]);
      check($sformatf("rr_wr1_%0d", i), m1_waitrequest, exp_wr1[i]);
      tick();
      check($sformatf("rr_rdv0_%0d", i), m0_readdatavalid, exp_rdv0[i]);
      check($sformatf("rr_rdv1_%0d", i), m1_readdatavalid, exp_rdv1[i]);
      check($sformatf("rr_not_both_%0d", i), m0_readdatavalid & m1_readdatavalid, 0);
      if (exp_rdv0[i]) check($sformatf("rr_data0_%0d", i), m0_readdata, TS);
      if (exp_rdv1[i]) check($sformatf("rr_data1_%0d", i), m1_readdata, TS);
    end
    m0_read = 1'b0; m1_read = 1'b0;
`endif

    // Reset the cycle after an m0 accept: strobe dropped, boot reruns.
    m0_read = 1'b1; m0_address = 1'b0;
    #1;
    check("abort_wr0", m0_waitrequest, 0);
    tick();
    m0_read = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_boot_done", boot_done, 0);
    check("abort_rdv0_a", m0_readdatavalid, 0);
    tick();
    check("abort_rdv0_b", m0_readdatavalid, 0);
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("abort_rdv0_e%0d", e), m0_readdatavalid, 0);
      if (e == 2) check("abort_reboot_pending", boot_done, 0);
    end
    check("abort_reboot_done", boot_done, 1);
    check("abort_reboot_ok", id_ok, 1);

    // Failing boot: ID reads 5, three attempts, id_fail after edge 9.
    id_val = 32'd5;
    do_reset();
    ts_cycles = 0;
    for (int e = 1; e <= 9; e++) begin
      if (sid_address) ts_cycles++;
      tick();
      if (e == 8) begin
        check("fail_done_e8", boot_done, 0);
        check("fail_flag_e8", id_fail, 0);
      end
    end
    check("fail_attempts", ts_cycles, 3);
    check("fail_boot_done", boot_done, 1);
    check("fail_id_fail", id_fail, 1);
    check("fail_id_ok", id_ok, 0);
    m0_read = 1'b1; m0_address = 1'b0;
    #1;
    check("fail_wr0", m0_waitrequest, 0);
    tick();
    m0_read = 1'b0;
    tick();
    check("fail_rdv0", m0_readdatavalid, 1);
    check("fail_data0", m0_readdata, 5);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
